enc_bundler: RTL



---
 rtl/enc_pkg.sv | 17 +
 rtl/enc_bundler_if.sv | 24 ++
 rtl/enc_bit_counter.sv | 41 ++++
 rtl/enc_bundler.sv | 90 +++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared constants and state type for the encoder bundler stage.
package enc_pkg;

  localparam int HV_DIM          = 1024;
  localparam int FEATURES_PER_CC = 8;
  localparam int NUM_CHUNKS      = 78;
  localparam int CNT_W           = $clog2(NUM_CHUNKS * FEATURES_PER_CC + 1);
  localparam int CHUNK_W         = $clog2(NUM_CHUNKS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    THRESH = 2'd2,
    DONE   = 2'd3
  } bundler_state_t;

endpackage

// File: rtl/enc_bundler_if.sv
// Chunk stream from the binders plus the bundled-sample result port.
interface enc_bundler_if;
  import enc_pkg::*;

  logic                                             start_encoding;
  logic [CNT_W-1:0]                                 threshold;
  logic                                             in_valid;
  logic [FEATURES_PER_CC-1:0]                       in_mask;
  logic [0:FEATURES_PER_CC-1][HV_DIM-1:0]           shifted_hv;
  logic                                             busy;
  logic                                             out_valid;
  logic [HV_DIM-1:0]                                bundled_hv;

  modport master (
    output start_encoding, threshold, in_valid, in_mask, shifted_hv,
    input  busy, out_valid, bundled_hv
  );

  modport slave (
    input  start_encoding, threshold, in_valid, in_mask, shifted_hv,
    output busy, out_valid, bundled_hv
  );

endinterface

// File: rtl/enc_bit_counter.sv
// One hypervector bit: lane popcount, running count and threshold compare.
module enc_bit_counter
  import enc_pkg::*;
(
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [FEATURES_PER_CC-1:0] lane_bits,
  input  logic                       clear,
  input  logic                       inc_en,
  input  logic [CNT_W-1:0]           thr_q,
  output logic                       ge
);

  logic [CNT_W-1:0] cnt_p0;
  logic [CNT_W-1:0] lane_sum;

  function automatic logic [CNT_W-1:0] lane_popcount(input logic [FEATURES_PER_CC-1:0] bits);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < FEATURES_PER_CC; i++) begin
      sum = sum + {{(CNT_W-1){1'b0}}, bits[i]};
    end
    return sum;
  endfunction

  assign lane_sum = lane_popcount(lane_bits);

  // Counter sized for the full sample, so it never wraps.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_p0 <= '0;
    end else if (clear) begin
      cnt_p0 <= '0;
    end else if (inc_en) begin
      cnt_p0 <= cnt_p0 + lane_sum;
    end
  end

  assign ge = (cnt_p0 >= thr_q);

endmodule

// File: rtl/enc_bundler.sv
// Bundles NUM_CHUNKS chunks of bound hypervectors into one thresholded sample.
module enc_bundler
  import enc_pkg::*;
(
  input  logic         clk,
  input  logic         nrst,
  enc_bundler_if.slave bus
);

  bundler_state_t      state;
  logic [CHUNK_W-1:0]  chunk_cnt;
  logic [CNT_W-1:0]    thr_q;
  logic [HV_DIM-1:0]   bundled_q;
  logic [HV_DIM-1:0]   ge_vec;
  logic                out_valid_q;
  logic                busy_q;
  logic                accept;

  // A restart in the same cycle as a chunk wins; that chunk is dropped.
  assign accept = (state == ACCUM) && bus.in_valid && !bus.start_encoding;

  for (genvar b = 0; b < HV_DIM; b++) begin : g_bit
    logic [FEATURES_PER_CC-1:0] lane_bits;

    always_comb begin
      lane_bits = '0;
      for (int i = 0; i < FEATURES_PER_CC; i++) begin
        lane_bits[i] = bus.shifted_hv[i][b] & bus.in_mask[i];
      end
    end

    enc_bit_counter u_cnt (
      .clk       (clk),
      .nrst      (nrst),
      .lane_bits (lane_bits),
      .clear     (bus.start_encoding),
      .inc_en    (accept),
      .thr_q     (thr_q),
      .ge        (ge_vec[b])
    );
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      chunk_cnt   <= '0;
      thr_q       <= '0;
      bundled_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.start_encoding) begin
        state     <= ACCUM;
        busy_q    <= 1'b1;
        chunk_cnt <= '0;
        thr_q     <= bus.threshold;
        bundled_q <= '0;
      end else begin
        case (state)
          ACCUM: begin
            if (bus.in_valid) begin
              chunk_cnt <= chunk_cnt + 1'b1;
              if (chunk_cnt == CHUNK_W'(NUM_CHUNKS - 1)) begin
                state <= THRESH;
              end
            end
          end
          THRESH: begin
            bundled_q   <= ge_vec;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= DONE;
          end
          IDLE, DONE: begin
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.bundled_hv = bundled_q;

endmodule
